cond_logic: RTL
===============

COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports are listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 cond  input  4  instruction condition field, ARM encoding.
REQ-005 aluflags  input  4  ALU flags {N,Z,C,V}, bit 3 = N, bit 0 = V.
REQ-006 flagw  input  2  flag write request: bit 1 = NZ group, bit 0 = CV group.
REQ-007 pcs  input  1  instruction writes the PC (branch or PC destination).
REQ-008 regw  input  1  instruction writes the register file.
REQ-009 memw  input  1  instruction writes memory.
REQ-010 nextpc  input  1  unconditional PC advance from the control FSM (fetch cycle).
REQ-011 pcwrite  output  1  gated PC write enable.
REQ-012 regwrite  output  1  gated register-file write enable.
REQ-013 memwrite  output  1  gated memory write enable.
REQ-014 flags  output  4  current architectural flag register {N,Z,C,V}.
REQ-015 condex  output  1  registered condition-pass bit for the instruction in flight.

Function
REQ-016 condex_c SHALL be the combinational condition result, evaluated from cond and the registered flags only (never from aluflags).
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: N
- 0101 PL: !N
- 0110 VS: V
- 0111 VC: !V
- 1000 HI: !Z&C
- 1001 LS: Z|!C
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: !Z&(N==V)
- 1101 LE: Z|(N!=V)
- 1110 AL: 1
- 1111: 0 (never executes, never X).
REQ-017 The NZ group SHALL load aluflags[3:2] on a clock edge iff flagw[1] & condex_c; otherwise it SHALL hold.
REQ-018 The CV group SHALL load aluflags[1:0] on a clock edge iff flagw[0] & condex_c; otherwise it SHALL hold.
REQ-019 The two flag groups SHALL update independently; flagw=2'b10 SHALL leave C,V unchanged.
REQ-020 The condex register SHALL load condex_c on every clock edge (one-cycle latency); the condex output SHALL equal this register.
REQ-021 Outputs SHALL be combinational from registered state:
- regwrite = regw & condex
- memwrite = memw & condex
- pcwrite = (pcs & condex) | nextpc
REQ-022 nextpc SHALL force pcwrite=1 regardless of condex or reset-cleared state.
REQ-023 Flag evaluation and flag update in the same cycle SHALL use the pre-update flags; the new flags SHALL be visible to condex_c from the next cycle.
REQ-024 The block SHALL contain no arithmetic; flags are only stored and decoded, never recomputed.

Reset
REQ-025 While reset=1 at a clock edge, flags SHALL become 4'b0000 and condex SHALL become 0, overriding any flag write.
REQ-026 After reset, regwrite=0 and memwrite=0; pcwrite SHALL equal nextpc.
REQ-027 Reset asserted mid-instruction SHALL discard the pending condex without partial flag updates.

Structure
REQ-028 A shared package SHALL hold:
- the 15 condition-code constants (EQ..AL)
- flag bit-index constants N=3, Z=2, C=1, V=0
- flagw bit indices NZ=1, CV=0.
REQ-029 Condition decoding SHALL live in one combinational sub-module, cond_check (inputs cond and flags, output condex_c); cond_logic holds the registers and output gating.

Verification
REQ-030 Reset: reset=1 for 1 cycle with flagw=2'b11 and aluflags=4'b1111 -> flags=4'b0000, condex=0, regwrite=memwrite=0.
REQ-031 Full code sweep: for each of the 16 flag values x 16 cond values, check condex one cycle after presentation against the REQ-016 table (256 checks); cond=1111 -> 0.
REQ-032 Split write: flags=0000, cond=AL, flagw=2'b10, aluflags=4'b1111 -> flags=4'b1100; next cycle flagw=2'b01 -> flags=4'b1111.
REQ-033 Suppressed write: flags=0100 (Z), cond=NE, flagw=2'b11, aluflags=4'b1001 -> flags remain 0100; next cycle regwrite=0 with regw=1.
REQ-034 Ordering: flags=0000, cond=EQ, flagw=2'b11, aluflags=0100 -> this cycle condex_c=0 so flags stay 0000; hold 1 cycle, then cond=EQ with flagw=0 -> condex=0.
REQ-035 PC gating: cond=EQ with Z=1, pcs=1, nextpc=0 -> pcwrite=1 the cycle after; Z=0 -> pcwrite=0; nextpc=1 -> pcwrite=1 in both cases.

Source files
------------

// File: rtl/cond_logic_pkg.sv
// rtl/cond_logic_pkg.sv - condition codes and flag bit indices shared by cond_logic
package cond_logic_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-field decode against stored flags
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex_c
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    condex_c = 1'b0;
    case (cond)
      COND_EQ: condex_c = z;
      COND_NE: condex_c = ~z;
      COND_CS: condex_c = c;
      COND_CC: condex_c = ~c;
      COND_MI: condex_c = n;
      COND_PL: condex_c = ~n;
      COND_VS: condex_c = v;
      COND_VC: condex_c = ~v;
      COND_HI: condex_c = ~z & c;
      COND_LS: condex_c = z | ~c;
      COND_GE: condex_c = ~(n ^ v);
      COND_LT: condex_c = n ^ v;
      COND_GT: condex_c = ~z & ~(n ^ v);
      COND_LE: condex_c = z | (n ^ v);
      COND_AL: condex_c = 1'b1;
      // 1111 is the never-execute slot
      default: condex_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - flag register, registered condition pass and write-enable gating
module cond_logic
  import cond_logic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic [1:0] flagw,
  input  logic       pcs,
  input  logic       regw,
  input  logic       memw,
  input  logic       nextpc,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic [3:0] flags,
  output logic       condex
);

  logic [3:0] flags_q;
  logic       condex_q;
  logic       condex_c;

  // Decode uses the stored flags, so a same-cycle flag write is seen next cycle.
  cond_check u_cond_check (
    .cond     (cond),
    .flags    (flags_q),
    .condex_c (condex_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      if (flagw[FW_NZ] && condex_c)
        flags_q[FLAG_N:FLAG_Z] <= aluflags[FLAG_N:FLAG_Z];
      if (flagw[FW_CV] && condex_c)
        flags_q[FLAG_C:FLAG_V] <= aluflags[FLAG_C:FLAG_V];
      condex_q <= condex_c;
    end
  end

  assign flags    = flags_q;
  assign condex   = condex_q;
  assign regwrite = regw & condex_q;
  assign memwrite = memw & condex_q;
  assign pcwrite  = (pcs & condex_q) | nextpc;

endmodule
